// File: rtl/spi_master_fifo_if.sv
// rtl/spi_master_fifo_if.sv - TX/RX word handshake bundle between register block and SPI master
interface spi_master_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - buffered SPI master with TX/RX FIFOs, bursts and abort
// Every timed state lasts div+1 clocks; config is latched when a sequence starts.
module spi_master_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int NUM_SS     = 2,
  parameter  int DIV_W      = 8,
  localparam int SEL_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_cpol,
  input  logic               i_cpha,
  input  logic               i_lsbfe,
  input  logic [DIV_W-1:0]   i_div,
  input  logic [SEL_W-1:0]   i_ss_sel,
  spi_master_fifo_if.slave   bus,
  output logic               o_busy,
  output logic               o_rx_ovf,
  output logic               o_sck,
  output logic               o_mosi,
  input  logic               i_miso,
  output logic [NUM_SS-1:0]  o_ss_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP} state_t;
  state_t r_state, w_next;

  logic              r_cpha, r_lsbfe;
  logic [DIV_W-1:0]  r_div;
  logic [SEL_W-1:0]  r_sel;
  logic [DIV_W-1:0]  r_cnt;
  logic [EW-1:0]     r_edge;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr;
  logic              r_sck, r_mosi, r_ovf;

  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

  logic              w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic              w_h_end, w_burst, w_xfer_edge, w_odd, w_sample, w_shift;
  logic              w_trail_first, w_cpha_eff, w_lsb_eff;
  logic [DATA_W-1:0] w_tx_head, w_rx_in;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

  assign w_h_end       = (r_cnt == r_div);
  assign w_burst       = (r_state == S_TRAIL) && w_h_end && !w_tx_empty && (i_ss_sel == r_sel);
  assign w_tx_push     = i_en && bus.tx_valid && !w_tx_full;
  assign w_tx_pop      = i_en && (((r_state == S_IDLE) && !w_tx_empty) || w_burst);
  assign w_trail_first = (r_state == S_TRAIL) && (r_cnt == '0);
  assign w_rx_push     = i_en && w_trail_first && !w_rx_full;
  assign w_rx_pop      = i_en && !w_rx_empty && bus.rx_ready;

  // In IDLE the live inputs apply, since they are being latched in the same cycle.
  assign w_cpha_eff = (r_state == S_IDLE) ? i_cpha  : r_cpha;
  assign w_lsb_eff  = (r_state == S_IDLE) ? i_lsbfe : r_lsbfe;

  // r_edge counts from 0, so an even count is an odd-numbered SCK edge.
  assign w_xfer_edge = (r_state == S_XFER) && w_h_end;
  assign w_odd       = !r_edge[0];
  assign w_sample    = w_xfer_edge && (r_cpha ? !w_odd : w_odd);
  assign w_shift     = w_xfer_edge && (r_cpha ? w_odd : !w_odd);
  assign w_rx_in     = r_lsbfe ? {i_miso, r_rx_sr[DATA_W-1:1]} : {r_rx_sr[DATA_W-2:0], i_miso};

  assign bus.tx_ready = !w_tx_full;
  assign bus.rx_valid = !w_rx_empty;
  assign bus.rx_data  = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!w_tx_empty) w_next = S_LEAD;
        S_LEAD:  if (w_h_end) w_next = S_XFER;
        S_XFER:  if (w_h_end && (r_edge == LAST_EDGE)) w_next = S_TRAIL;
        S_TRAIL: if (w_h_end) w_next = w_burst ? S_XFER : S_GAP;
        S_GAP:   if (w_h_end) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy   = (r_state != S_IDLE);
    o_sck    = (r_state == S_IDLE) ? i_cpol : r_sck;
    o_mosi   = r_mosi;
    o_rx_ovf = r_ovf;
    o_ss_n   = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if ((r_state inside {S_LEAD, S_XFER, S_TRAIL}) && (r_sel == SEL_W'(i))) o_ss_n[i] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpha  <= 1'b0;
      r_lsbfe <= 1'b0;
      r_div   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_h_end || (w_next != r_state)) r_cnt <= '0;
      else                                                       r_cnt <= r_cnt + 1'b1;

      if ((r_state == S_IDLE) && (w_next == S_LEAD)) begin
        r_cpha  <= i_cpha;
        r_lsbfe <= i_lsbfe;
        r_div   <= i_div;
        r_sel   <= i_ss_sel;
      end

      if (r_state != S_XFER) r_edge <= '0;
      else if (w_h_end)      r_edge <= r_edge + 1'b1;

      if (r_state == S_IDLE) r_sck <= i_cpol;
      else if (w_xfer_edge)  r_sck <= !r_sck;

      // With cpha=0 the first bit must already be on MOSI before the first edge.
      if (w_tx_pop) begin
        if (!w_cpha_eff) begin
          r_mosi  <= w_lsb_eff ? w_tx_head[0] : w_tx_head[DATA_W-1];
          r_tx_sr <= w_lsb_eff ? {1'b0, w_tx_head[DATA_W-1:1]} : {w_tx_head[DATA_W-2:0], 1'b0};
        end else begin
          r_tx_sr <= w_tx_head;
        end
      end else if (w_shift) begin
        r_mosi  <= r_lsbfe ? r_tx_sr[0] : r_tx_sr[DATA_W-1];
        r_tx_sr <= r_lsbfe ? {1'b0, r_tx_sr[DATA_W-1:1]} : {r_tx_sr[DATA_W-2:0], 1'b0};
      end

      if (w_sample) r_rx_sr <= w_rx_in;

      if (!i_en)                          r_ovf <= 1'b0;
      else if (w_trail_first && w_rx_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else if (!i_en) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sr;
  end
endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
Parametrised, buffered SPI master engine. It is the next-generation replacement for the fixed 8-bit, single-slave master datapath.
- Generalises data width, FIFO depth and slave-select count.
- Adds TX/RX FIFOs with valid/ready handshakes.
- Supports back-to-back burst frames with SS held low, RX overflow flagging, and immediate abort.
- Sits between the bus-side register block and the pad-side port logic.

Parameters:
DATA_W, 8, bits per SPI frame (>=4)
FIFO_DEPTH, 4, entries per TX and RX FIFO (power of 2, >=2)
NUM_SS, 2, number of slave-select outputs (>=1)
DIV_W, 8, width of the baud divider input

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  core enable; low aborts and flushes
cpol  in  1  SCK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsbfe  in  1  1: LSB first
div  in  DIV_W  SCK half-period = div+1 clk cycles
ss_sel  in  max(1,$clog2(NUM_SS))  target slave index
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  push request, TX FIFO
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_W  head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  pop request, RX FIFO
busy  out  1  frame sequence in progress
rx_ovf  out  1  sticky RX overflow flag
sck  out  1  serial clock
mosi  out  1  serial data out
miso  in  1  serial data in
ss_n  out  NUM_SS  active-low slave selects

Behaviour:
Reset (rst low, async) and outputs at reset:
- FIFOs empty; FSM in IDLE.
- tx_ready=1, rx_valid=0, rx_data=0, busy=0, rx_ovf=0, ss_n all 1, mosi=0.
- sck = cpol.

FIFOs:
- Push when valid&ready; pop when rx_valid&rx_ready.
- Simultaneous push and pop leave the count unchanged.
- TX push while full is ignored (tx_ready=0).
- rx_data is first-word-fall-through.

Config latching:
- cpol, cpha, lsbfe, div and ss_sel are latched on IDLE->LEAD and held for the whole sequence.
- Exception: sck idle level tracks cpol live while in IDLE.

Timing unit: all timed states last H = div+1 clk cycles ("half period").

FSM:
- IDLE: busy=0. If en and TX not empty: pop TX word into shift register, go to LEAD.
- LEAD: ss_n[sel]=0 for 1 H. If cpha=0, mosi presents the first bit.
- XFER: 2*DATA_W half periods. sck toggles at the end of each H.
  - cpha=0: sample miso on odd edges (1,3,..), shift on even edges.
  - cpha=1: shift on odd edges, sample on even edges.
  - Bit order: MSB first, or LSB first if lsbfe.
- TRAIL: 1 H with ss_n held low, sck at cpol.
  - On entry, the received word is pushed to RX. If RX is full, the word is dropped and rx_ovf is set.
  - At exit: if TX not empty and live ss_sel equals the latched ss_sel, pop the next word and go to XFER (burst, SS stays low). Otherwise go to GAP.
- GAP: ss_n all 1 for 1 H, then IDLE.

Single-word timing:
- busy is high from the LEAD entry through the end of GAP: 2*DATA_W+3 half periods.
- ss_n is low for 2*DATA_W+2 half periods.

Status:
- rx_ovf stays set until en is low or reset.

Abort:
- en low in any state: next clk returns to IDLE, ss_n all 1, sck=cpol, both FIFOs flushed, rx_ovf cleared.
- No partial word is pushed to RX.
- Pushes while en is low are ignored.

Other rules:
- Divider counter restarts on every state entry.
- div=0 gives SCK = clk/2.
- Changing the config inputs mid-sequence has no effect until the next IDLE->LEAD.

Test Plan:
- Mode 0, div=1, DATA_W=8, push 0xA5, miso looped to mosi -> ss_n[0] low for 36 clk; 8 rising sck edges with mosi 1,0,1,0,0,1,0,1; rx_data=0xA5; busy high 38 clk.
- Modes 1/2/3 with lsbfe=1, push 0x3C, slave model returns 0xC3 -> mosi bits LSB first; sampling on the correct edge per mode; rx_data=0xC3; sck idles at cpol.
- Burst: push 0x11,0x22,0x33 with ss_sel=1 -> ss_n[1] low continuously across 3 frames, ss_n[0] stays 1; RX holds 0x11,0x22,0x33 in order (loopback).
- Overflow: FIFO_DEPTH=4, rx_ready=0, send 5 words -> RX holds the first 4; rx_ovf=1 after the 5th TRAIL; tx_ready=0 while TX holds 4 entries.
- Abort: drop en during bit 3 of a frame -> next clk ss_n all 1, sck=cpol, busy=0, rx_valid=0, tx_ready=1.
- Reset: assert rst low mid-XFER, asynchronously and between clk edges -> outputs reach reset values immediately; no RX push afterwards.
